// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - fetch-stage state encoding and fault instruction constant
package if_fetch_pkg;

    typedef enum logic [2:0] {
        IF_FETCH_IDLE = 3'd0,
        IF_FETCH_REQ  = 3'd1,
        IF_FETCH_WAIT = 3'd2,
        IF_FETCH_DROP = 3'd3,
        IF_FETCH_HOLD = 3'd4
    } if_fetch_state_e;

    localparam logic [31:0] IF_FETCH_NOP_INST = 32'h0000_0013;

    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - single-outstanding instruction fetch stage between PC register and decode
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(IF_FETCH_NOP_INST)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_fetch_pc_i,
    input  logic              if_fetch_flush_i,
    input  logic              if_fetch_dont_fetch_i,
    output logic              if_fetch_req_valid_o,
    input  logic              if_fetch_req_ready_i,
    output logic [ADDR_W-1:0] if_fetch_req_addr_o,
    input  logic              if_fetch_resp_valid_i,
    input  logic              if_fetch_resp_err_i,
    input  logic [INST_W-1:0] if_fetch_resp_data_i,
    output logic              if_fetch_inst_valid_o,
    input  logic              if_fetch_id_ready_i,
    output logic [INST_W-1:0] if_fetch_inst_o,
    output logic [ADDR_W-1:0] if_fetch_inst_addr_o,
    output logic              if_fetch_acc_fault_o,
    output logic              if_fetch_misalign_o,
    output logic              if_fetch_pc_adv_o
);

    if_fetch_state_e   state_q, state_d;
    logic              kill_q, kill_d;
    logic [ADDR_W-1:0] req_addr_q;
    logic [INST_W-1:0] inst_q;
    logic [ADDR_W-1:0] inst_addr_q;
    logic              acc_fault_q;
    logic              misalign_q;

    logic start_fetch;
    logic pc_bad;
    logic capture_resp;

    assign start_fetch  = (state_q == IF_FETCH_IDLE) && !if_fetch_flush_i && !if_fetch_dont_fetch_i;
    assign pc_bad       = pc_misaligned(if_fetch_pc_i[1:0]);
    assign capture_resp = (state_q == IF_FETCH_WAIT) && if_fetch_resp_valid_i && !if_fetch_flush_i;

    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        case (state_q)
            IF_FETCH_IDLE: begin
                if (start_fetch) begin
                    state_d = pc_bad ? IF_FETCH_HOLD : IF_FETCH_REQ;
                end
            end
            IF_FETCH_REQ: begin
                // The request cannot be retracted, so a flush only marks its response for discard.
                if (if_fetch_flush_i) begin
                    kill_d = 1'b1;
                end
                if (if_fetch_req_ready_i) begin
                    state_d = (kill_q || if_fetch_flush_i) ? IF_FETCH_DROP : IF_FETCH_WAIT;
                    kill_d  = 1'b0;
                end
            end
            IF_FETCH_WAIT: begin
                if (if_fetch_resp_valid_i) begin
                    state_d = if_fetch_flush_i ? IF_FETCH_IDLE : IF_FETCH_HOLD;
                end else if (if_fetch_flush_i) begin
                    state_d = IF_FETCH_DROP;
                end
            end
            IF_FETCH_DROP: begin
                if (if_fetch_resp_valid_i) begin
                    state_d = IF_FETCH_IDLE;
                end
            end
            IF_FETCH_HOLD: begin
                if (if_fetch_flush_i || if_fetch_id_ready_i) begin
                    state_d = IF_FETCH_IDLE;
                end
            end
            default: begin
                state_d = IF_FETCH_IDLE;
                kill_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IF_FETCH_IDLE;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr_q  <= '0;
            inst_q      <= NOP_INST;
            inst_addr_q <= '0;
            acc_fault_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            if (start_fetch) begin
                if (pc_bad) begin
                    inst_q      <= NOP_INST;
                    inst_addr_q <= if_fetch_pc_i;
                    acc_fault_q <= 1'b0;
                    misalign_q  <= 1'b1;
                end else begin
                    req_addr_q <= {if_fetch_pc_i[ADDR_W-1:2], 2'b00};
                end
            end
            if (capture_resp) begin
                inst_q      <= if_fetch_resp_err_i ? NOP_INST : if_fetch_resp_data_i;
                inst_addr_q <= req_addr_q;
                acc_fault_q <= if_fetch_resp_err_i;
                misalign_q  <= 1'b0;
            end
        end
    end

    assign if_fetch_req_valid_o  = (state_q == IF_FETCH_REQ);
    assign if_fetch_req_addr_o   = req_addr_q;
    assign if_fetch_inst_valid_o = (state_q == IF_FETCH_HOLD);
    assign if_fetch_inst_o       = inst_q;
    assign if_fetch_inst_addr_o  = inst_addr_q;
    assign if_fetch_acc_fault_o  = acc_fault_q;
    assign if_fetch_misalign_o   = misalign_q;
    assign if_fetch_pc_adv_o     = (state_q == IF_FETCH_HOLD) && if_fetch_id_ready_i && !if_fetch_flush_i;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed and randomized self-checking bench for if_fetch
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] pc = 64'd0;
    logic        flush = 1'b0;
    logic        dont_fetch = 1'b0;
    logic        req_valid;
    logic        ready = 1'b1;
    logic [63:0] req_addr;
    logic        resp_valid = 1'b0;
    logic        resp_err = 1'b0;
    logic [31:0] resp_data = 32'd0;
    logic        inst_valid;
    logic        id_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_addr;
    logic        acc_fault;
    logic        misalign;
    logic        pc_adv;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk                   (clk),
        .rst                   (rst),
        .if_fetch_pc_i         (pc),
        .if_fetch_flush_i      (flush),
        .if_fetch_dont_fetch_i (dont_fetch),
        .if_fetch_req_valid_o  (req_valid),
        .if_fetch_req_ready_i  (ready),
        .if_fetch_req_addr_o   (req_addr),
        .if_fetch_resp_valid_i (resp_valid),
        .if_fetch_resp_err_i   (resp_err),
        .if_fetch_resp_data_i  (resp_data),
        .if_fetch_inst_valid_o (inst_valid),
        .if_fetch_id_ready_i   (id_ready),
        .if_fetch_inst_o       (inst),
        .if_fetch_inst_addr_o  (inst_addr),
        .if_fetch_acc_fault_o  (acc_fault),
        .if_fetch_misalign_o   (misalign),
        .if_fetch_pc_adv_o     (pc_adv)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: a request is open until accepted, its response is
    // owed until delivered, and any flush during its life throws the result away.
    logic        m_req = 1'b0, m_kill = 1'b0, m_wait = 1'b0, m_drop = 1'b0, m_held = 1'b0;
    logic [63:0] m_req_addr = 64'd0, m_addr = 64'd0;
    logic [31:0] m_inst = NOP;
    logic        m_af = 1'b0, m_ma = 1'b0;
    logic        seen_rst = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_req <= 1'b0; m_kill <= 1'b0; m_wait <= 1'b0; m_drop <= 1'b0; m_held <= 1'b0;
            m_req_addr <= 64'd0; m_addr <= 64'd0; m_inst <= NOP; m_af <= 1'b0; m_ma <= 1'b0;
            seen_rst <= 1'b1;
        end else if (m_held) begin
            if (flush || id_ready) m_held <= 1'b0;
        end else if (m_req) begin
            if (ready) begin
                m_req  <= 1'b0;
                m_kill <= 1'b0;
                if (m_kill || flush) m_drop <= 1'b1;
                else m_wait <= 1'b1;
            end else if (flush) begin
                m_kill <= 1'b1;
            end
        end else if (m_wait) begin
            if (resp_valid) begin
                m_wait <= 1'b0;
                if (!flush) begin
                    m_held <= 1'b1;
                    m_inst <= resp_err ? NOP : resp_data;
                    m_addr <= m_req_addr;
                    m_af   <= resp_err;
                    m_ma   <= 1'b0;
                end
            end else if (flush) begin
                m_wait <= 1'b0;
                m_drop <= 1'b1;
            end
        end else if (m_drop) begin
            if (resp_valid) m_drop <= 1'b0;
        end else if (!(flush || dont_fetch)) begin
            if (pc[1:0] != 2'b00) begin
                m_held <= 1'b1; m_inst <= NOP; m_addr <= pc; m_af <= 1'b0; m_ma <= 1'b1;
            end else begin
                m_req <= 1'b1; m_req_addr <= pc;
            end
        end
    end

    logic        prev_stall = 1'b0;
    logic [63:0] prev_addr = 64'd0;

    initial begin
        forever begin
            @(negedge clk);
            if (seen_rst) begin
                chk("req_valid", 64'(req_valid), 64'(m_req));
                if (m_req) chk("req_addr", req_addr, m_req_addr);
                chk("inst_valid", 64'(inst_valid), 64'(m_held));
                if (m_held) begin
                    chk("inst", 64'(inst), 64'(m_inst));
                    chk("inst_addr", inst_addr, m_addr);
                    chk("acc_fault", 64'(acc_fault), 64'(m_af));
                    chk("misalign", 64'(misalign), 64'(m_ma));
                end
                chk("pc_adv", 64'(pc_adv), 64'(m_held && id_ready && !flush));
                if (prev_stall) begin
                    chk("req_hold_valid", 64'(req_valid), 64'd1);
                    chk("req_hold_addr", req_addr, prev_addr);
                end
                prev_stall = req_valid && !ready && !rst;
                prev_addr  = req_addr;
            end
        end
    end

    // Memory: at most one outstanding response, delivered 1+delay cycles after handshake.
    int          mem_cnt = 0;
    logic [63:0] mem_addr = 64'd0;
    int          mem_delay_fix = 0;
    int          mem_delay_max = 2;
    bit          mem_rand_ready = 1'b0;
    int          ready_low = 0;
    bit          mem_reset_en = 1'b1;
    bit          mem_fixed_en = 1'b1;
    logic [31:0] mem_fixed = 32'h0000_0297;
    bit          force_err = 1'b0;
    int          err_pct = 0;
    int          hs_count = 0;

    initial begin
        logic rs;
        forever begin
            @(posedge clk);
            rs = rst;
            #1;
            if (rs && mem_reset_en) mem_cnt = 0;
            resp_valid = 1'b0;
            resp_err   = 1'b0;
            resp_data  = $urandom;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    resp_valid = 1'b1;
                    resp_err   = force_err || ($urandom_range(99) < err_pct);
                    resp_data  = mem_fixed_en ? mem_fixed : (mem_addr[31:0] ^ $urandom);
                end
            end
            if (mem_cnt > 0) begin
                ready = 1'b0;
            end else if (ready_low > 0 && req_valid) begin
                ready = 1'b0;
                ready_low--;
            end else begin
                ready = mem_rand_ready ? ($urandom_range(2) != 0) : 1'b1;
            end
            if (req_valid && ready && mem_cnt == 0) begin
                hs_count++;
                mem_addr = req_addr;
                mem_cnt  = 1 + ((mem_delay_fix >= 0) ? mem_delay_fix : int'($urandom_range(mem_delay_max)));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        int hs0;
        logic [31:0] held_inst;
        logic [63:0] held_addr;

        // Test 1: basic fetch latency and reset values
        step(); step();
        rst = 1'b0; pc = 64'h8000_0000; id_ready = 1'b1;
        at_neg();
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_req_addr", req_addr, 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'h13);
        chk("rst_inst_addr", inst_addr, 64'd0);
        chk("rst_faults", 64'({acc_fault, misalign}), 64'd0);
        chk("rst_pc_adv", 64'(pc_adv), 64'd0);
        step(); dont_fetch = 1'b1;
        at_neg();
        chk("t1_req_valid", 64'(req_valid), 64'd1);
        chk("t1_req_addr", req_addr, 64'h8000_0000);
        step();
        at_neg();
        chk("t2_inst_valid", 64'(inst_valid), 64'd0);
        step();
        at_neg();
        chk("t3_inst_valid", 64'(inst_valid), 64'd1);
        chk("t3_inst", 64'(inst), 64'h297);
        chk("t3_inst_addr", inst_addr, 64'h8000_0000);
        chk("t3_pc_adv", 64'(pc_adv), 64'd1);
        repeat (2) step();

        // Test 2: ready stalls for three cycles, one handshake only
        hs0 = hs_count; ready_low = 3; pc = 64'h8000_0004; dont_fetch = 1'b0;
        step(); dont_fetch = 1'b1;
        repeat (10) step();
        chk("t2_handshakes", 64'(hs_count - hs0), 64'd1);

        // Test 3: flush in WAIT, stale response two cycles later
        mem_fixed = 32'hDEAD_BEEF; mem_delay_fix = 2; pc = 64'h8000_0800; dont_fetch = 1'b0;
        step(); dont_fetch = 1'b1;
        step(); flush = 1'b1; pc = 64'h8000_1000;
        at_neg(); chk("t3_flush_no_valid", 64'(inst_valid), 64'd0);
        step(); flush = 1'b0;
        repeat (3) begin at_neg(); chk("t3_flush_no_valid", 64'(inst_valid), 64'd0); step(); end
        dont_fetch = 1'b0; mem_fixed = 32'h0010_0093; mem_delay_fix = 0;
        step(); dont_fetch = 1'b1;
        at_neg();
        chk("t3_new_req_valid", 64'(req_valid), 64'd1);
        chk("t3_new_req_addr", req_addr, 64'h8000_1000);
        repeat (4) step();

        // Test 4: decode stalls five cycles, then flush beats id_ready
        id_ready = 1'b0; pc = 64'h8000_2000; dont_fetch = 1'b0;
        step(); dont_fetch = 1'b1;
        step(); step();
        at_neg();
        held_inst = inst; held_addr = inst_addr;
        chk("t4_held_valid", 64'(inst_valid), 64'd1);
        repeat (5) begin
            step(); at_neg();
            chk("t4_stall_inst", 64'(inst), 64'(held_inst));
            chk("t4_stall_addr", inst_addr, held_addr);
            chk("t4_stall_adv", 64'(pc_adv), 64'd0);
        end
        step(); flush = 1'b1; id_ready = 1'b1;
        at_neg(); chk("t4_flush_no_adv", 64'(pc_adv), 64'd0);
        step(); flush = 1'b0;
        at_neg(); chk("t4_flush_dropped", 64'(inst_valid), 64'd0);

        // Test 5: misaligned PC, then bus error
        pc = 64'h8000_0002; dont_fetch = 1'b0;
        step(); dont_fetch = 1'b1;
        at_neg();
        chk("t5_mis_no_req", 64'(req_valid), 64'd0);
        chk("t5_mis_valid", 64'(inst_valid), 64'd1);
        chk("t5_mis_flag", 64'(misalign), 64'd1);
        chk("t5_mis_inst", 64'(inst), 64'h13);
        step();
        force_err = 1'b1; pc = 64'h8000_0010; dont_fetch = 1'b0;
        step(); dont_fetch = 1'b1;
        step(); step();
        at_neg();
        chk("t5_err_valid", 64'(inst_valid), 64'd1);
        chk("t5_err_fault", 64'(acc_fault), 64'd1);
        chk("t5_err_inst", 64'(inst), 64'h13);
        step(); force_err = 1'b0;

        // Test 6: reset during WAIT, late response must be ignored
        mem_reset_en = 1'b0; mem_delay_fix = 2; pc = 64'h8000_0020; dont_fetch = 1'b0;
        step(); dont_fetch = 1'b1;
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        at_neg();
        chk("t6_rst_req_valid", 64'(req_valid), 64'd0);
        chk("t6_rst_req_addr", req_addr, 64'd0);
        chk("t6_rst_inst", 64'(inst), 64'h13);
        chk("t6_rst_inst_addr", inst_addr, 64'd0);
        chk("t6_rst_faults", 64'({acc_fault, misalign, pc_adv}), 64'd0);
        repeat (5) begin
            step(); at_neg();
            chk("t6_late_ignored", 64'(inst_valid), 64'd0);
        end
        mem_reset_en = 1'b1;

        // Randomized traffic
        mem_fixed_en = 1'b0; mem_delay_fix = -1; mem_rand_ready = 1'b1; err_pct = 10;
        repeat (3000) begin
            step();
            rst        = ($urandom_range(199) == 0);
            flush      = ($urandom_range(9) == 0);
            dont_fetch = ($urandom_range(5) == 0);
            id_ready   = ($urandom_range(1) == 1);
            pc         = {$urandom, $urandom};
            if ($urandom_range(7) != 0) pc[1:0] = 2'b00;
        end
        step(); rst = 1'b0; flush = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
